// File: rtl/fetch_controller_if.sv
// Instruction-memory read channel between the fetch controller and memory.
interface fetch_controller_if #(
  parameter int DataWidth = 16
);
  logic                 MemReq;
  logic [DataWidth-1:0] MemAddr;
  logic                 MemAck;
  logic [DataWidth-1:0] MemData;

  modport master (output MemReq, MemAddr, input MemAck, MemData);
  modport slave  (input MemReq, MemAddr, output MemAck, MemData);
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: FETCH -> EXEC -> UPDATE loop with fetch timeout,
// halt handling and PC load/increment strobes.
module fetch_controller #(
  parameter int DataWidth     = 16,
  parameter int WordByteSize  = 2,
  parameter int TimeoutCycles = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Halt,
  input  logic [DataWidth-1:0] PCIn,
  input  logic                 ExecDone,
  input  logic                 BranchTaken,
  input  logic [DataWidth-1:0] BranchTarget,
  fetch_controller_if.master   mem,
  output logic                 PC_LD,
  output logic                 PC_INC,
  output logic [DataWidth-1:0] PC_DIn,
  output logic [DataWidth-1:0] IR,
  output logic                 IRValid,
  output logic                 Halted,
  output logic                 Fault,
  output logic [2:0]           State
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0]  TimeoutLimit = CntWidth'(TimeoutCycles);
  // Clears the byte-offset bits so branch targets land on a word boundary.
  localparam logic [DataWidth-1:0] AlignMask = ~DataWidth'(WordByteSize - 1);

  logic [2:0]           state_q, state_d;
  logic [CntWidth-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DataWidth-1:0] ir_q, ir_d;
  logic [DataWidth-1:0] pc_din_q, pc_din_d;
  logic                 branch_q, branch_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    pc_din_d   = pc_din_q;
    branch_d   = branch_q;
    case (state_q)
      ST_IDLE: if (Run) state_d = ST_FETCH;
      ST_FETCH: begin
        // An ack in the timeout cycle still completes the fetch.
        if (mem.MemAck) begin
          ir_d       = mem.MemData;
          wait_cnt_d = '0;
          state_d    = ST_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == TimeoutLimit) state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        if (ExecDone) begin
          if (Halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d  = ST_UPDATE;
            branch_d = BranchTaken;
            pc_din_d = BranchTarget & AlignMask;
          end
        end
      end
      ST_UPDATE: state_d = Run ? ST_FETCH : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ir_q       <= '0;
      pc_din_q   <= '0;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
      pc_din_q   <= pc_din_d;
      branch_q   <= branch_d;
    end
  end

  assign mem.MemReq  = (state_q == ST_FETCH);
  assign mem.MemAddr = PCIn;
  assign PC_LD       = !((state_q == ST_UPDATE) && branch_q);
  assign PC_INC      = (state_q == ST_UPDATE) && !branch_q;
  assign PC_DIn      = pc_din_q;
  assign IR          = ir_q;
  assign IRValid     = (state_q == ST_EXEC);
  assign Halted      = (state_q == ST_HALTED);
  assign Fault       = (state_q == ST_FAULT);
  assign State       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed scenarios push expected
// events; a negedge monitor pops and compares as the DUT produces them.
module tb_fetch_controller;

  localparam int EV_STATE  = 0;
  localparam int EV_FETCH  = 1;
  localparam int EV_RETIRE = 2;
  localparam int EV_LOAD   = 3;
  localparam int EV_INC    = 4;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Reset, Run, Halt, ExecDone, BranchTaken;
  logic [15:0] PCIn, BranchTarget;
  logic        PC_LD, PC_INC, IRValid, Halted, Fault;
  logic [15:0] PC_DIn, IR;
  logic [2:0]  State;
  logic [15:0] pc;
  logic [2:0]  prev_state;
  logic        mon_en = 1'b0;

  int  n_total = 0;
  int  n_pass  = 0;
  ev_t exp_q[$];

  fetch_controller_if #(.DataWidth(16)) bus ();

  fetch_controller #(.DataWidth(16), .WordByteSize(2), .TimeoutCycles(15)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Halt(Halt), .PCIn(PCIn),
    .ExecDone(ExecDone), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .mem(bus), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_DIn(PC_DIn), .IR(IR),
    .IRValid(IRValid), .Halted(Halted), .Fault(Fault), .State(State)
  );

  always #5 Clk = ~Clk;

  // Program counter register driven by the DUT strobes.
  always @(posedge Clk) begin
    if (Reset)        pc <= 16'h0000;
    else if (!PC_LD)  pc <= PC_DIn;
    else if (PC_INC)  pc <= pc + 16'd2;
  end
  assign PCIn = pc;

  function automatic string kname(input int kind);
    case (kind)
      EV_STATE:  return "state";
      EV_FETCH:  return "fetch_addr";
      EV_RETIRE: return "retire_ir";
      EV_LOAD:   return "pc_load";
      default:   return "pc_inc";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] val);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s 0x%04h, required none", kname(kind), val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val) n_pass++;
      else $display("FAIL event: got %s 0x%04h, required %s 0x%04h",
                    kname(kind), val, kname(e.kind), e.val);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      n_total++;
      if (bus.MemReq == (State == 3'd1) && IRValid == (State == 3'd2) &&
          Halted == (State == 3'd4) && Fault == (State == 3'd5) &&
          (State == 3'd3 || (PC_LD && !PC_INC)) && !(!PC_LD && PC_INC))
        n_pass++;
      else
        $display("FAIL outputs_vs_state: State=%0d MemReq=%b IRValid=%b Halted=%b Fault=%b PC_LD=%b PC_INC=%b",
                 State, bus.MemReq, IRValid, Halted, Fault, PC_LD, PC_INC);
      if (State != prev_state)      observe(EV_STATE, {13'd0, State});
      if (bus.MemReq && bus.MemAck) observe(EV_FETCH, bus.MemAddr);
      if (IRValid && ExecDone)      observe(EV_RETIRE, IR);
      if (!PC_LD)                   observe(EV_LOAD, PC_DIn);
      if (PC_INC)                   observe(EV_INC, 16'h0000);
    end
    prev_state <= State;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Fetch waits 14 cycles, is acked in the 15th, retires with Run dropped.
  task automatic fetch_ack15(input logic [15:0] addr, input logic [15:0] data);
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_FETCH, addr);
    expect_ev(EV_STATE, 16'd2); expect_ev(EV_RETIRE, data);
    expect_ev(EV_STATE, 16'd3); expect_ev(EV_INC, 16'h0000);
    expect_ev(EV_STATE, 16'd0);
    Run = 1'b1; bus.MemAck = 1'b0; ExecDone = 1'b0; bus.MemData = data;
    tick(15);
    bus.MemAck = 1'b1;
    tick(1);
    bus.MemAck = 1'b0; Run = 1'b0; ExecDone = 1'b1;
    tick(2);
    ExecDone = 1'b0;
    tick(2);
  endtask

  task automatic do_reset;
    expect_ev(EV_STATE, 16'd0);
    tick(1);
    Reset = 1'b1; Run = 1'b0; bus.MemAck = 1'b0; ExecDone = 1'b0; Halt = 1'b0;
    BranchTaken = 1'b0;
    tick(1);
    Reset = 1'b0;
    tick(2);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Halt = 1'b0; ExecDone = 1'b0; BranchTaken = 1'b0;
    BranchTarget = 16'h0000; bus.MemAck = 1'b0; bus.MemData = 16'h0000;
    tick(2);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_state", {13'd0, State}, 16'd0);
    chk("reset_memreq", {15'd0, bus.MemReq}, 16'd0);
    chk("reset_pc_ld", {15'd0, PC_LD}, 16'd1);
    chk("reset_pc_inc", {15'd0, PC_INC}, 16'd0);
    chk("reset_pc_din", PC_DIn, 16'h0000);
    chk("reset_ir", IR, 16'h0000);
    chk("reset_irvalid", {15'd0, IRValid}, 16'd0);
    chk("reset_halted", {15'd0, Halted}, 16'd0);
    chk("reset_fault", {15'd0, Fault}, 16'd0);
    mon_en = 1'b1;
    tick(1);

    // Zero-wait fetch with increment, then a branch to an odd target.
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_FETCH, 16'h0000);
    expect_ev(EV_STATE, 16'd2); expect_ev(EV_RETIRE, 16'h1234);
    expect_ev(EV_STATE, 16'd3); expect_ev(EV_INC, 16'h0000);
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_FETCH, 16'h0002);
    expect_ev(EV_STATE, 16'd2); expect_ev(EV_RETIRE, 16'h5678);
    expect_ev(EV_STATE, 16'd3); expect_ev(EV_LOAD, 16'h00A0);
    expect_ev(EV_STATE, 16'd0);
    Run = 1'b1; bus.MemAck = 1'b1; bus.MemData = 16'h1234; ExecDone = 1'b1;
    tick(3);
    bus.MemData = 16'h5678; BranchTaken = 1'b1; BranchTarget = 16'h00A1;
    tick(3);
    Run = 1'b0; BranchTaken = 1'b0;
    tick(3);

    // Run dropped during EXEC: instruction and increment complete, then idle.
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_FETCH, 16'h00A0);
    expect_ev(EV_STATE, 16'd2); expect_ev(EV_RETIRE, 16'h1111);
    expect_ev(EV_STATE, 16'd3); expect_ev(EV_INC, 16'h0000);
    expect_ev(EV_STATE, 16'd0);
    Run = 1'b1; ExecDone = 1'b0; bus.MemAck = 1'b1; bus.MemData = 16'h1111;
    tick(2);
    Run = 1'b0; ExecDone = 1'b1;
    tick(2);
    ExecDone = 1'b0;
    tick(3);

    fetch_ack15(16'h00A2, 16'h2222);

    // Ack withheld for the full timeout: FAULT, then inputs are ignored.
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_STATE, 16'd5);
    Run = 1'b1; bus.MemAck = 1'b0;
    tick(16);
    bus.MemAck = 1'b1; ExecDone = 1'b1; Halt = 1'b1;
    repeat (4) begin Run = ~Run; tick(1); end
    @(negedge Clk);
    chk("fault_state", {13'd0, State}, 16'd5);
    chk("fault_flag", {15'd0, Fault}, 16'd1);
    chk("fault_memreq", {15'd0, bus.MemReq}, 16'd0);
    chk("fault_halted", {15'd0, Halted}, 16'd0);
    do_reset;

    // Halt together with a taken branch: no PC strobe, Run has no effect.
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_FETCH, 16'h0000);
    expect_ev(EV_STATE, 16'd2); expect_ev(EV_RETIRE, 16'h3333);
    expect_ev(EV_STATE, 16'd4);
    Run = 1'b1; bus.MemAck = 1'b1; bus.MemData = 16'h3333; ExecDone = 1'b0;
    Halt = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0050;
    tick(2);
    ExecDone = 1'b1;
    tick(1);
    repeat (6) begin Run = ~Run; tick(1); end
    @(negedge Clk);
    chk("halt_state", {13'd0, State}, 16'd4);
    chk("halt_flag", {15'd0, Halted}, 16'd1);
    chk("halt_pc_ld", {15'd0, PC_LD}, 16'd1);
    chk("halt_pc_inc", {15'd0, PC_INC}, 16'd0);
    do_reset;

    // Reset in the middle of a fetch wait; a late ack must be ignored and the
    // wait counter must restart from zero.
    expect_ev(EV_STATE, 16'd1); expect_ev(EV_STATE, 16'd0);
    Run = 1'b1; bus.MemAck = 1'b0;
    tick(5);
    Reset = 1'b1; Run = 1'b0;
    tick(1);
    Reset = 1'b0; bus.MemAck = 1'b1;
    tick(3);
    @(negedge Clk);
    chk("rst_fetch_state", {13'd0, State}, 16'd0);
    chk("rst_fetch_memreq", {15'd0, bus.MemReq}, 16'd0);
    tick(1);
    bus.MemAck = 1'b0;
    fetch_ack15(16'h0000, 16'h4444);

    tick(3);
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_event: got none, required %s 0x%04h", kname(e.kind), e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DataWidth, default 16, address/instruction width.
REQ-002 SHALL have parameter WordByteSize, default 2, bytes per instruction word; PC step size.
REQ-003 SHALL have parameter TimeoutCycles, default 15, maximum FETCH cycles without MemAck.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port Run  input  1  permits fetching new instructions.
REQ-007 SHALL have port Halt  input  1  halt request, sampled with ExecDone.
REQ-008 SHALL have port PCIn  input  DataWidth  current program counter value.
REQ-009 SHALL have port MemAck  input  1  memory read data valid.
REQ-010 SHALL have port MemData  input  DataWidth  instruction word from memory.
REQ-011 SHALL have port ExecDone  input  1  execute stage finished current instruction.
REQ-012 SHALL have port BranchTaken  input  1  next PC comes from BranchTarget.
REQ-013 SHALL have port BranchTarget  input  DataWidth  branch destination address.
REQ-014 SHALL have port MemReq  output  1  memory read request.
REQ-015 SHALL have port MemAddr  output  DataWidth  read address.
REQ-016 SHALL have port PC_LD  output  1  PC load strobe, active-low.
REQ-017 SHALL have port PC_INC  output  1  PC increment-by-WordByteSize strobe, active-high.
REQ-018 SHALL have port PC_DIn  output  DataWidth  value for PC load.
REQ-019 SHALL have port IR  output  DataWidth  instruction register.
REQ-020 SHALL have port IRValid  output  1  IR holds instruction under execution.
REQ-021 SHALL have ports Halted, Fault  output  1 each  sticky status flags.
REQ-022 SHALL have port State  output  3  encoding IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALTED=4, FAULT=5.

Function
REQ-023 IDLE: Run=1 -> FETCH next cycle; else stay.
REQ-024 FETCH: MemReq=1, MemAddr=PCIn (combinational); held until MemAck=1 sampled.
REQ-025 FETCH with MemAck=1: IR<=MemData, wait counter cleared, -> EXEC; zero-wait ack gives single-cycle FETCH.
REQ-026 FETCH with MemAck=0: wait counter +1; counter reaching TimeoutCycles -> FAULT; MemAck in that same cycle wins (-> EXEC).
REQ-027 EXEC: IRValid=1, MemReq=0; stay until ExecDone=1.
REQ-028 EXEC with ExecDone=1: Halt=1 -> HALTED (no PC update, Halt overrides BranchTaken); else -> UPDATE, latching BranchTaken and BranchTarget.
REQ-029 UPDATE (exactly one cycle): branch -> PC_LD=0, PC_DIn=BranchTarget with low log2(WordByteSize) bits forced 0; else PC_INC=1; never both.
REQ-030 UPDATE -> FETCH if Run=1, else IDLE; deasserting Run mid-instruction finishes instruction and PC update first.
REQ-031 PC_LD=1 and PC_INC=0 in every state other than UPDATE.
REQ-032 HALTED: Halted=1, no requests; FAULT: Fault=1, no requests; both exit only via Reset.
REQ-033 IRValid=0 outside EXEC; IR retains last value until next ack.
REQ-034 MemAck, ExecDone, Halt, BranchTaken SHALL be ignored outside the states named above.

Reset
REQ-035 Reset=1 at a rising edge: State=IDLE, MemReq=0, PC_LD=1, PC_INC=0, PC_DIn=0, IR=0, IRValid=0, Halted=0, Fault=0, wait counter=0.
REQ-036 Reset SHALL take priority over every transition including mid-FETCH and mid-UPDATE; an UPDATE strobe coinciding with Reset is dropped the following cycle.

Verification
REQ-037 Reset, Run=1, PCIn=0x0000, MemAck same cycle with MemData=0x1234, ExecDone next cycle -> MemReq one cycle at addr 0x0000, IR=0x1234, IRValid one cycle, PC_INC one cycle, back to FETCH.
REQ-038 ExecDone with BranchTaken=1, BranchTarget=0x00A1 -> PC_LD=0 one cycle, PC_DIn=0x00A0, PC_INC stays 0.
REQ-039 MemAck withheld 15 cycles -> State=FAULT, Fault=1, MemReq=0; ack on 15th cycle instead -> EXEC, Fault=0.
REQ-040 ExecDone with Halt=1 and BranchTaken=1 -> HALTED, Halted=1, no PC_LD/PC_INC pulse; Run toggling has no effect.
REQ-041 Run dropped during EXEC -> PC_INC pulse in UPDATE, then IDLE, MemReq=0.
REQ-042 Reset asserted during FETCH wait -> next cycle State=IDLE, MemReq=0, counter=0; late MemAck ignored.
